// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response and the decode hand-off.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst_out;
  logic [15:0] pc_plus2_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_q;
  logic        halt;

  modport master (
    output imem_req, imem_addr, inst_out, pc_plus2_out, inst_valid, pc_q, halt,
    input  imem_ack, imem_data, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, pc_plus2_out, inst_valid, pc_q, halt,
    output imem_ack, imem_data, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch: request one word, hold it for decode, then fetch the next.
// Redirects replace the PC and drop any buffered word; an accepted HLT parks the unit until reset.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_inst;
  logic [15:0] w_inst_nxt;
  logic [15:0] r_pc2;
  logic [15:0] w_pc2_nxt;
  logic [15:0] w_redirect_pc;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  // Instructions are halfword aligned, so bit 0 of a redirect target is discarded.
  assign w_redirect_pc = bus.redirect_pc & 16'hFFFE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= 16'h0000;
      r_pc2   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_inst  <= w_inst_nxt;
      r_pc2   <= w_pc2_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_pc2_nxt   = r_pc2;
    unique case (r_state)
      FETCH: begin
        if (bus.redirect) begin
          w_pc_nxt = w_redirect_pc;
        end else if (bus.imem_ack) begin
          w_inst_nxt  = bus.imem_data;
          w_pc2_nxt   = pc_inc(r_pc);
          w_pc_nxt    = pc_inc(r_pc);
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Redirect wins even over accepting an HLT sitting in the buffer.
        if (bus.redirect) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = FETCH;
        end else if (bus.inst_ready) begin
          w_state_nxt = (r_inst[15:12] == 4'hF) ? HALTED : FETCH;
        end
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = FETCH;
    endcase
  end

  assign bus.imem_req     = (r_state == FETCH);
  assign bus.imem_addr    = r_pc;
  assign bus.inst_valid   = (r_state == HOLD);
  assign bus.halt         = (r_state == HALTED);
  assign bus.inst_out     = r_inst;
  assign bus.pc_plus2_out = r_pc2;
  assign bus.pc_q         = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshakes with stalls, redirect priority, PC wrap and halt.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = 16'h0000;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;

    // Asynchronous reset, before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_pc",     bus.pc_q,         16'h0000);
    chk("rst_inst",   bus.inst_out,     16'h0000);
    chk("rst_pc2",    bus.pc_plus2_out, 16'h0000);
    chk("rst_valid",  {15'd0, bus.inst_valid}, 16'h0000);
    chk("rst_halt",   {15'd0, bus.halt},       16'h0000);
    step();
    step();
    rst = 1'b0;

    // First cycle after reset release: request at RESET_PC, ack immediately
    chk("rel_req",  {15'd0, bus.imem_req}, 16'h0001);
    chk("rel_addr", bus.imem_addr,         16'h0000);
    bus.imem_ack   = 1'b1;
    bus.imem_data  = 16'h1234;
    bus.inst_ready = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("b1_valid", {15'd0, bus.inst_valid}, 16'h0001);
    chk("b1_inst",  bus.inst_out,            16'h1234);
    chk("b1_pc2",   bus.pc_plus2_out,        16'h0002);
    chk("b1_pc",    bus.pc_q,                16'h0002);
    chk("b1_req",   {15'd0, bus.imem_req},   16'h0000);
    step();
    bus.inst_ready = 1'b0;
    chk("b1_next_req",  {15'd0, bus.imem_req}, 16'h0001);
    chk("b1_next_addr", bus.imem_addr,         16'h0002);
    chk("b1_next_val",  {15'd0, bus.inst_valid}, 16'h0000);

    // Memory stalls: request held three cycles, ack arrives in the third
    step();
    chk("st_req2", {15'd0, bus.imem_req}, 16'h0001);
    step();
    chk("st_req3", {15'd0, bus.imem_req}, 16'h0001);
    chk("st_addr", bus.imem_addr,         16'h0002);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h5678;
    step();
    bus.imem_ack = 1'b0;
    chk("st_val1",  {15'd0, bus.inst_valid}, 16'h0001);
    chk("st_inst1", bus.inst_out,            16'h5678);
    chk("st_pc2",   bus.pc_plus2_out,        16'h0004);
    step();
    chk("st_val2",  {15'd0, bus.inst_valid}, 16'h0001);
    chk("st_inst2", bus.inst_out,            16'h5678);
    chk("st_pc_hold", bus.pc_q,              16'h0004);
    step();
    chk("st_val3",  {15'd0, bus.inst_valid}, 16'h0001);
    chk("st_inst3", bus.inst_out,            16'h5678);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("st_acc_val",  {15'd0, bus.inst_valid}, 16'h0000);
    chk("st_acc_req",  {15'd0, bus.imem_req},   16'h0001);
    chk("st_acc_addr", bus.imem_addr,           16'h0004);

    // Redirect in HOLD beats acceptance of a buffered HLT
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hF111;
    step();
    bus.imem_ack = 1'b0;
    chk("rh_inst", bus.inst_out, 16'hF111);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0041;
    bus.inst_ready  = 1'b1;
    step();
    bus.redirect   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("rh_valid", {15'd0, bus.inst_valid}, 16'h0000);
    chk("rh_addr",  bus.imem_addr,           16'h0040);
    chk("rh_halt",  {15'd0, bus.halt},       16'h0000);
    chk("rh_req",   {15'd0, bus.imem_req},   16'h0001);

    // Redirect in FETCH beats a same-cycle ack
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    bus.imem_ack    = 1'b1;
    bus.imem_data   = 16'hAAAA;
    step();
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b0;
    chk("rf_pc",    bus.pc_q,                16'h0100);
    chk("rf_req",   {15'd0, bus.imem_req},   16'h0001);
    chk("rf_valid", {15'd0, bus.inst_valid}, 16'h0000);
    chk("rf_inst",  bus.inst_out,            16'hF111);

    // Ack while no request is outstanding is ignored
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h2222;
    step();
    bus.imem_data = 16'h3333;
    step();
    bus.imem_ack = 1'b0;
    chk("ia_inst", bus.inst_out, 16'h2222);
    chk("ia_pc",   bus.pc_q,     16'h0102);
    chk("ia_pc2",  bus.pc_plus2_out, 16'h0102);

    // Redirect to an odd address near the top, then fetch an HLT at 16'hFFFE
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect = 1'b0;
    chk("wr_addr", bus.imem_addr, 16'hFFFE);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hF000;
    step();
    bus.imem_ack = 1'b0;
    chk("wr_pc2",  bus.pc_plus2_out, 16'h0000);
    chk("wr_pc",   bus.pc_q,         16'h0000);
    chk("wr_inst", bus.inst_out,     16'hF000);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("hl_halt",  {15'd0, bus.halt},       16'h0001);
    chk("hl_req",   {15'd0, bus.imem_req},   16'h0000);
    chk("hl_valid", {15'd0, bus.inst_valid}, 16'h0000);

    // HALTED ignores redirect, ack and ready
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    bus.imem_ack    = 1'b1;
    bus.inst_ready  = 1'b1;
    step();
    step();
    bus.redirect   = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    chk("hl2_halt", {15'd0, bus.halt},     16'h0001);
    chk("hl2_pc",   bus.pc_q,              16'h0000);
    chk("hl2_req",  {15'd0, bus.imem_req}, 16'h0000);

    // Reset pulse between clock edges leaves HALTED immediately
    #2 rst = 1'b1;
    #1;
    chk("ar_halt", {15'd0, bus.halt},     16'h0000);
    chk("ar_pc",   bus.pc_q,              16'h0000);
    chk("ar_inst", bus.inst_out,          16'h0000);
    chk("ar_req",  {15'd0, bus.imem_req}, 16'h0001);
    step();
    rst = 1'b0;
    chk("ar_rel_addr", bus.imem_addr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
